// File: rtl/pipe_ctrl.sv
// Hazard/redirect controller for the 5-stage pipeline: arbitrates bus wait, jump,
// multi-cycle divide, load-use and interrupt entry into stall/flush/redirect controls.
module pipe_ctrl #(
  parameter int XLEN             = 32,
  parameter int INT_ENTRY_CYCLES = 3,
  parameter int DIV_MAX          = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_wait_i,
  input  logic            jump_req_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            div_start_i,
  input  logic            div_done_i,
  input  logic            load_use_i,
  input  logic            irq_req_i,
  input  logic [XLEN-1:0] irq_vec_i,
  output logic [4:0]      stall_o,
  output logic [3:0]      flush_o,
  output logic            pc_redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            irq_ack_o,
  output logic            div_err_o
);

  localparam int CNT_MAX = (DIV_MAX > INT_ENTRY_CYCLES) ? DIV_MAX : INT_ENTRY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_MAX - 1);
  localparam logic [CNT_W-1:0] IRQ_LAST = CNT_W'(INT_ENTRY_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DIV, IRQ} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   irq_vec_q;
  logic              div_err;

  logic              go_div;
  logic              go_irq;
  logic              go_run;
  logic              cnt_inc;
  logic              set_err;

  always_comb begin
    stall_o       = 5'b00000;
    flush_o       = 4'b0000;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    irq_ack_o     = 1'b0;
    go_div        = 1'b0;
    go_irq        = 1'b0;
    go_run        = 1'b0;
    cnt_inc       = 1'b0;
    set_err       = 1'b0;
    // A memory wait freezes everything and defers every other request.
    if (bus_wait_i) begin
      stall_o = 5'b11111;
    end else begin
      case (state)
        RUN: begin
          if (jump_req_i) begin
            pc_redirect_o = 1'b1;
            pc_target_o   = jump_addr_i;
            flush_o       = 4'b0011;
          end else if (div_start_i) begin
            stall_o = 5'b00111;
            flush_o = 4'b0100;
            go_div  = 1'b1;
          end else if (load_use_i) begin
            stall_o = 5'b00011;
            flush_o = 4'b0010;
          end else if (irq_req_i) begin
            stall_o = 5'b00001;
            flush_o = 4'b0001;
            go_irq  = 1'b1;
          end
        end
        DIV: begin
          // Done wins over the watchdog when both land in the same cycle.
          if (div_done_i) begin
            go_run = 1'b1;
          end else if (cnt == DIV_LAST) begin
            go_run  = 1'b1;
            set_err = 1'b1;
          end else begin
            stall_o = 5'b00111;
            flush_o = 4'b0100;
            cnt_inc = 1'b1;
          end
        end
        IRQ: begin
          stall_o = 5'b00001;
          flush_o = 4'b0011;
          if (cnt == IRQ_LAST) begin
            pc_redirect_o = 1'b1;
            pc_target_o   = irq_vec_q;
            irq_ack_o     = 1'b1;
            go_run        = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: go_run = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      irq_vec_q <= '0;
      div_err   <= 1'b0;
    end else begin
      if (go_div) begin
        state <= DIV;
        cnt   <= '0;
      end else if (go_irq) begin
        state     <= IRQ;
        cnt       <= '0;
        irq_vec_q <= irq_vec_i;
      end else if (go_run) begin
        state <= RUN;
        cnt   <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (set_err) begin
        div_err <= 1'b1;
      end
    end
  end

  assign div_err_o = div_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus randomized traffic,
// checked against a countdown-based behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int INTC = 3;
  localparam int DMAX = 40;

  typedef struct packed {
    logic [4:0]      stall;
    logic [3:0]      flush;
    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            ack;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            bus_wait_i = 1'b0;
  logic            jump_req_i = 1'b0;
  logic [XLEN-1:0] jump_addr_i = '0;
  logic            div_start_i = 1'b0;
  logic            div_done_i = 1'b0;
  logic            load_use_i = 1'b0;
  logic            irq_req_i = 1'b0;
  logic [XLEN-1:0] irq_vec_i = '0;
  logic [4:0]      stall_o;
  logic [3:0]      flush_o;
  logic            pc_redirect_o;
  logic [XLEN-1:0] pc_target_o;
  logic            irq_ack_o;
  logic            div_err_o;

  pipe_ctrl #(.XLEN(XLEN), .INT_ENTRY_CYCLES(INTC), .DIV_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus_wait_i(bus_wait_i), .jump_req_i(jump_req_i),
    .jump_addr_i(jump_addr_i), .div_start_i(div_start_i), .div_done_i(div_done_i),
    .load_use_i(load_use_i), .irq_req_i(irq_req_i), .irq_vec_i(irq_vec_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .irq_ack_o(irq_ack_o), .div_err_o(div_err_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  // Reference model: interrupt entry as cycles remaining to redirect,
  // divide as elapsed cycles since entering the busy phase.
  int              m_irq_left = 0, n_irq_left = 0;
  logic [XLEN-1:0] m_irq_tgt = '0, n_irq_tgt = '0;
  bit              m_div = 0, n_div = 0;
  int              m_div_el = 0, n_div_el = 0;
  bit              m_err = 0, n_err = 0;

  task automatic model_reset();
    m_irq_left = 0; m_irq_tgt = '0; m_div = 0; m_div_el = 0; m_err = 0;
    n_irq_left = 0; n_irq_tgt = '0; n_div = 0; n_div_el = 0; n_err = 0;
  endtask

  task automatic commit();
    m_irq_left = n_irq_left; m_irq_tgt = n_irq_tgt;
    m_div = n_div; m_div_el = n_div_el; m_err = n_err;
  endtask

  task automatic model_eval(output exp_t e);
    e = '0;
    e.err = m_err;
    n_irq_left = m_irq_left; n_irq_tgt = m_irq_tgt;
    n_div = m_div; n_div_el = m_div_el; n_err = m_err;
    if (bus_wait_i) begin
      e.stall = 5'b11111;
    end else if (m_irq_left > 0) begin
      e.stall = 5'b00001;
      e.flush = 4'b0011;
      n_irq_left = m_irq_left - 1;
      if (m_irq_left == 1) begin
        e.redir = 1'b1; e.tgt = m_irq_tgt; e.ack = 1'b1;
      end
    end else if (m_div) begin
      if (div_done_i) begin
        n_div = 0;
      end else if (m_div_el == DMAX - 1) begin
        n_div = 0; n_err = 1;
      end else begin
        e.stall = 5'b00111; e.flush = 4'b0100; n_div_el = m_div_el + 1;
      end
    end else if (jump_req_i) begin
      e.redir = 1'b1; e.tgt = jump_addr_i; e.flush = 4'b0011;
    end else if (div_start_i) begin
      e.stall = 5'b00111; e.flush = 4'b0100; n_div = 1; n_div_el = 0;
    end else if (load_use_i) begin
      e.stall = 5'b00011; e.flush = 4'b0010;
    end else if (irq_req_i) begin
      e.stall = 5'b00001; e.flush = 4'b0001; n_irq_left = INTC; n_irq_tgt = irq_vec_i;
    end
  endtask

  task automatic cyc(input logic bw, input logic j, input logic [XLEN-1:0] ja,
                     input logic ds, input logic dd, input logic lu,
                     input logic irq, input logic [XLEN-1:0] iv);
    exp_t e;
    @(posedge clk); #1;
    commit();
    rst_n = 1'b1;
    bus_wait_i = bw; jump_req_i = j; jump_addr_i = ja; div_start_i = ds;
    div_done_i = dd; load_use_i = lu; irq_req_i = irq; irq_vec_i = iv;
    model_eval(e);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic reset_cycle();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_wait_i = 0; jump_req_i = 0; jump_addr_i = '0; div_start_i = 0;
    div_done_i = 0; load_use_i = 0; irq_req_i = 0; irq_vec_i = '0;
    model_reset();
    model_eval(e);
    model_reset();
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("stall",  XLEN'(stall_o),       XLEN'(e.stall));
      chk("flush",  XLEN'(flush_o),       XLEN'(e.flush));
      chk("redir",  XLEN'(pc_redirect_o), XLEN'(e.redir));
      chk("target", pc_target_o,          e.tgt);
      chk("ack",    XLEN'(irq_ack_o),     XLEN'(e.ack));
      chk("err",    XLEN'(div_err_o),     XLEN'(e.err));
    end
  end

  initial begin
    model_reset();
    reset_cycle();
    idle(10);
    // Jump: redirect in the request cycle only
    cyc(0, 1, 32'h0000_1000, 0, 0, 0, 0, '0);
    idle(2);
    // Divide with done after 5 cycles
    cyc(0, 0, '0, 1, 0, 0, 0, '0);
    idle(4);
    cyc(0, 0, '0, 0, 1, 0, 0, '0);
    idle(2);
    // Divide that never completes: watchdog and sticky error
    cyc(0, 0, '0, 1, 0, 0, 0, '0);
    idle(DMAX + 5);
    // Interrupt entry
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h0000_0200);
    idle(5);
    // Interrupt entry stretched by 4 bus-wait cycles at cnt=1
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h0000_0300);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 0, 0, 0, '0);
    idle(4);
    // Reset mid-entry, then jump and irq together
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h0000_0400);
    idle(1);
    reset_cycle();
    cyc(0, 1, 32'h0000_2000, 0, 0, 0, 1, 32'h0000_0500);
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h0000_0500);
    idle(5);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), $urandom,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 299) == 0) reset_cycle();
    end
    idle(2);
    @(negedge clk); #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
